// File: rtl/fifo_param.sv
// fifo_param: single-clock parameterised FIFO with programmable almost-full/almost-empty thresholds and sticky error flags.
// Latency: the read word appears one cycle after an accepted read, or immediately on fifo_out when FIFO_FWFT_EN is defined.
// Backpressure: a write to a full FIFO is dropped unless a read is accepted in the same cycle; a read of an empty FIFO is ignored.
// Build option: define FIFO_FWFT_EN for first-word-fall-through output; leave it undefined for registered-read output.
module fifo_param #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo_in,
  input  logic              fifo_wr,
  input  logic              fifo_rd,
  input  logic [CNT_W-1:0]  full_umbral,
  input  logic [CNT_W-1:0]  empty_umbral,
  output logic [DATA_W-1:0] fifo_out,
  output logic              fifo_valid,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  // Pointers index DEPTH entries; CNT_W carries one extra bit so the count can reach DEPTH.
  localparam int PTR_W = CNT_W - 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              rd_acc;
  logic              wr_acc;

  // Flags decode only from the registered count, so no request input reaches them combinationally.
  assign full         = (fifo_count == CNT_W'(DEPTH));
  assign empty        = (fifo_count == '0);
  assign almost_full  = (fifo_count >= full_umbral);
  assign almost_empty = (fifo_count <= empty_umbral);

  // A read frees a slot this same edge, which lets a write into a full FIFO go through.
  assign rd_acc = fifo_rd && !empty;
  assign wr_acc = fifo_wr && (!full || rd_acc);

  // Storage write; reset suppresses it so a write during reset leaves no trace.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[tail] <= fifo_in;
    end
  end

  // Head/tail pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_acc) tail <= tail + PTR_W'(1);
      if (rd_acc) head <= head + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky error flags: a dropped write or a read of an empty FIFO is remembered until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (fifo_wr && full && !rd_acc) overflow  <= 1'b1;
      if (fifo_rd && empty)           underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown directly; forced to zero when empty so stale memory never leaks out.
  assign fifo_out   = empty ? '0 : mem[head];
  assign fifo_valid = !empty;
`else
  // Registered read port: capture the head word on an accepted read, hold it otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_out   <= '0;
      fifo_valid <= 1'b0;
    end else begin
      fifo_valid <= rd_acc;
      if (rd_acc) fifo_out <= mem[head];
    end
  end
`endif

endmodule
